// File: rtl/cond_exec_scoreboard_if.sv
// cond_exec_scoreboard_if: issue-stage, unit handshake and flag signals of the conditional-execution scoreboard
interface cond_exec_scoreboard_if #(parameter int NUM_UNITS = 2);
  logic                   Valid;
  logic [3:0]             Cond;
  logic [3:0]             FlagW;
  logic                   PCS;
  logic                   RegW;
  logic                   MemW;
  logic                   NoWrite;
  logic                   LogicOp;
  logic [3:0]             ALUFlags;
  logic                   ShifterCarry;
  logic [NUM_UNITS-1:0]   UnitReq;
  logic [NUM_UNITS-1:0]   UnitDone;
  logic [4*NUM_UNITS-1:0] UnitFlags;
  logic                   PCSrc;
  logic                   RegWrite;
  logic                   MemWrite;
  logic [NUM_UNITS-1:0]   UnitGo;
  logic                   Stall;
  logic [3:0]             Flags;
  logic                   CFlag;
  logic                   FlagPending;
  logic                   UnitErr;
  modport master(
    output Valid, Cond, FlagW, PCS, RegW, MemW, NoWrite, LogicOp, ALUFlags, ShifterCarry,
           UnitReq, UnitDone, UnitFlags,
    input  PCSrc, RegWrite, MemWrite, UnitGo, Stall, Flags, CFlag, FlagPending, UnitErr
  );
  modport slave(
    input  Valid, Cond, FlagW, PCS, RegW, MemW, NoWrite, LogicOp, ALUFlags, ShifterCarry,
           UnitReq, UnitDone, UnitFlags,
    output PCSrc, RegWrite, MemWrite, UnitGo, Stall, Flags, CFlag, FlagPending, UnitErr
  );
endinterface

// File: rtl/cond_exec_scoreboard.sv
// cond_exec_scoreboard: ARM condition gating with NZCV, multi-cycle unit busy/flag scoreboard and pending-op watchdog
module cond_exec_scoreboard #(
  parameter int NUM_UNITS = 2,
  parameter int TIMEOUT   = 64
) (
  input logic CLK,
  input logic Reset,
  cond_exec_scoreboard_if.slave bus
);
  localparam int IW = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1;
  localparam int CW = $clog2(TIMEOUT);
  logic [3:0]           flags, mask, alu, uf, flags_d, flags_n;
  logic [NUM_UNITS-1:0] busy, go;
  logic [IW-1:0]        idx, go_idx;
  logic [CW-1:0]        cnt;
  logic                 pending, err, cond_ex, al, stall, issue, exec, done_hit, expire, alu_wr, unit_wr;
  always_comb begin
    cond_ex = 1'b1;
    case (bus.Cond)
      4'd0:  cond_ex = flags[2];
      4'd1:  cond_ex = ~flags[2];
      4'd2:  cond_ex = flags[1];
      4'd3:  cond_ex = ~flags[1];
      4'd4:  cond_ex = flags[3];
      4'd5:  cond_ex = ~flags[3];
      4'd6:  cond_ex = flags[0];
      4'd7:  cond_ex = ~flags[0];
      4'd8:  cond_ex = flags[1] & ~flags[2];
      4'd9:  cond_ex = ~flags[1] | flags[2];
      4'd10: cond_ex = flags[3] == flags[0];
      4'd11: cond_ex = flags[3] != flags[0];
      4'd12: cond_ex = ~flags[2] & (flags[3] == flags[0]);
      4'd13: cond_ex = flags[2] | (flags[3] != flags[0]);
      default: cond_ex = 1'b1;
    endcase
  end
  always_comb begin
    go_idx = '0;
    for (int i = 0; i < NUM_UNITS; i++)
      if (bus.UnitReq[i]) go_idx = IW'(i);
  end
  // Stall looks only at registered scoreboard state, never at cond_ex
  assign al       = &bus.Cond[3:1];
  assign stall    = bus.Valid & ((pending & (~al | |bus.FlagW)) | |(bus.UnitReq & busy));
  assign issue    = bus.Valid & ~stall;
  assign exec     = issue & cond_ex;
  assign go       = bus.UnitReq & {NUM_UNITS{exec}};
  assign alu_wr   = exec & ~|bus.UnitReq;
  assign unit_wr  = |go & |bus.FlagW;
  assign done_hit = pending & bus.UnitDone[idx];
  assign expire   = pending & ~bus.UnitDone[idx] & (cnt == CW'(TIMEOUT - 1));
  assign uf       = bus.UnitFlags[{idx, 2'b00} +: 4];
  assign alu      = {bus.ALUFlags[3:2], bus.LogicOp ? bus.ShifterCarry : bus.ALUFlags[1], bus.ALUFlags[0]};
  assign flags_d  = done_hit ? (flags & ~mask) | (uf & mask) : flags;
  assign flags_n  = alu_wr ? (flags_d & ~bus.FlagW) | (alu & bus.FlagW) : flags_d;
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      flags   <= '0;
      busy    <= '0;
      pending <= 1'b0;
      mask    <= '0;
      idx     <= '0;
      cnt     <= '0;
      err     <= 1'b0;
    end else begin
      flags   <= flags_n;
      busy    <= (busy & ~bus.UnitDone & ~({NUM_UNITS{expire}} & (NUM_UNITS'(1) << idx))) | go;
      pending <= unit_wr | (pending & ~done_hit & ~expire);
      cnt     <= unit_wr ? '0 : cnt + 1'b1;
      err     <= err | expire;
      if (unit_wr) begin
        mask <= bus.FlagW;
        idx  <= go_idx;
      end
    end
  end
  assign bus.Stall       = stall;
  assign bus.PCSrc       = exec & bus.PCS;
  assign bus.RegWrite    = exec & bus.RegW & ~bus.NoWrite;
  assign bus.MemWrite    = exec & bus.MemW;
  assign bus.UnitGo      = go;
  assign bus.Flags       = flags;
  assign bus.CFlag       = flags[1];
  assign bus.FlagPending = pending;
  assign bus.UnitErr     = err;
endmodule

// File: tb/tb_cond_exec_scoreboard.sv
// tb_cond_exec_scoreboard: directed scenarios plus random issue traffic against a behavioural scoreboard model
module tb_cond_exec_scoreboard;
  localparam int N  = 2;
  localparam int TO = 64;
  logic CLK = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;
  cond_exec_scoreboard_if #(.NUM_UNITS(N)) bus();
  cond_exec_scoreboard #(.NUM_UNITS(N), .TIMEOUT(TO)) dut(.CLK(CLK), .Reset(Reset), .bus(bus.slave));
  int errors = 0;
  int checks = 0;
  logic [3:0]   m_flags, m_mask, pre;
  logic [N-1:0] m_busy;
  bit           m_pend, m_err;
  int           m_idx, m_age;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      0: return z;
      1: return !z;
      2: return cy;
      3: return !cy;
      4: return n;
      5: return !n;
      6: return v;
      7: return !v;
      8: return cy && !z;
      9: return !cy || z;
      10: return n == v;
      11: return n != v;
      12: return !z && n == v;
      13: return z || n != v;
      default: return 1'b1;
    endcase
  endfunction
  task automatic idle();
    bus.Valid = 0; bus.Cond = 4'd14; bus.FlagW = 0; bus.PCS = 0; bus.RegW = 0; bus.MemW = 0;
    bus.NoWrite = 0; bus.LogicOp = 0; bus.ALUFlags = 0; bus.ShifterCarry = 0;
    bus.UnitReq = 0; bus.UnitDone = 0; bus.UnitFlags = 0;
  endtask
  task automatic do_reset();
    Reset = 1'b1;
    #1;
    m_flags = 0; m_busy = 0; m_pend = 0; m_err = 0; m_mask = 0; m_idx = 0; m_age = 0;
    check("rst_flags", bus.Flags, 0);
    check("rst_pend", bus.FlagPending, 0);
    check("rst_err", bus.UnitErr, 0);
    @(negedge CLK);
    Reset = 1'b0;
  endtask
  // one clock: check combinational gating, advance the model, check registered state
  task automatic step();
    bit st, ex, dh, to;
    logic [N-1:0] go;
    logic [3:0] nf;
    #1;
    st = bus.Valid && ((m_pend && (bus.Cond < 14 || bus.FlagW != 0)) || (bus.UnitReq & m_busy) != 0);
    ex = bus.Valid && !st && cond_ok(bus.Cond, m_flags);
    go = ex ? bus.UnitReq : '0;
    check("stall", bus.Stall, st);
    check("pcsrc", bus.PCSrc, ex && bus.PCS);
    check("regwrite", bus.RegWrite, ex && bus.RegW && !bus.NoWrite);
    check("memwrite", bus.MemWrite, ex && bus.MemW);
    check("unitgo", bus.UnitGo, go);
    nf = m_flags;
    dh = m_pend && bus.UnitDone[m_idx];
    to = m_pend && !dh && m_age == TO - 1;
    if (dh) for (int b = 0; b < 4; b++) if (m_mask[b]) nf[b] = bus.UnitFlags[4*m_idx+b];
    if (ex && bus.UnitReq == 0)
      for (int b = 0; b < 4; b++)
        if (bus.FlagW[b]) nf[b] = (b == 1 && bus.LogicOp) ? bus.ShifterCarry : bus.ALUFlags[b];
    m_busy = m_busy & ~bus.UnitDone;
    if (to) m_busy[m_idx] = 1'b0;
    m_busy = m_busy | go;
    if (to) m_err = 1;
    if (go != 0 && bus.FlagW != 0) begin
      m_pend = 1; m_mask = bus.FlagW; m_age = 0;
      for (int i = 0; i < N; i++) if (go[i]) m_idx = i;
    end else if (dh || to) m_pend = 0;
    else if (m_pend) m_age++;
    m_flags = nf;
    @(posedge CLK);
    #1;
    check("flags", bus.Flags, m_flags);
    check("cflag", bus.CFlag, m_flags[1]);
    check("pending", bus.FlagPending, m_pend);
    check("uniterr", bus.UnitErr, m_err);
    @(negedge CLK);
  endtask
  initial begin
    idle();
    @(negedge CLK);
    do_reset();
    #1;
    check("rst_pcsrc", bus.PCSrc, 0);
    check("rst_stall", bus.Stall, 0);
    // ADDS setting Z, then BEQ
    bus.Valid = 1; bus.Cond = 4'd14; bus.FlagW = 4'hF; bus.ALUFlags = 4'b0100; bus.RegW = 1;
    step();
    check("t1_flags", bus.Flags, 4'b0100);
    bus.Cond = 4'd0; bus.FlagW = 0; bus.RegW = 0; bus.PCS = 1;
    #1;
    check("t1_beq", bus.PCSrc, 1);
    step();
    // ANDS carry from shifter vs ALU
    idle(); bus.Valid = 1; bus.FlagW = 4'hF; bus.LogicOp = 1; bus.ShifterCarry = 1; bus.ALUFlags = 4'b0000;
    step();
    check("t2_logic_c", bus.CFlag, 1);
    bus.LogicOp = 0;
    step();
    check("t2_arith_c", bus.CFlag, 0);
    bus.ALUFlags = 4'b1011;
    step();
    pre = bus.Flags;
    // MULS on unit0 then MOVEQ interlocked until done
    idle(); bus.Valid = 1; bus.FlagW = 4'b1100; bus.UnitReq = 2'b01; bus.RegW = 1;
    step();
    check("t3_pend", bus.FlagPending, 1);
    idle(); bus.Valid = 1; bus.Cond = 4'd0; bus.RegW = 1;
    #1;
    check("t3_stall", bus.Stall, 1);
    step();
    step();
    bus.UnitDone = 2'b01; bus.UnitFlags = 8'h04;
    step();
    check("t3_flags", bus.Flags, {2'b01, pre[1:0]});
    bus.UnitDone = 0;
    #1;
    check("t3_moveq", bus.RegWrite, 1);
    step();
    // unit1 busy interlock
    idle(); bus.Valid = 1; bus.UnitReq = 2'b10;
    step();
    #1;
    check("t4_stall", bus.Stall, 1);
    check("t4_go", bus.UnitGo, 0);
    step();
    bus.UnitReq = 0; bus.RegW = 1;
    #1;
    check("t4_alu_nostall", bus.Stall, 0);
    step();
    idle(); bus.UnitDone = 2'b10;
    step();
    // watchdog expiry
    idle(); bus.Valid = 1; bus.FlagW = 4'hF; bus.UnitReq = 2'b01;
    step();
    pre = bus.Flags;
    idle();
    for (int k = 0; k < TO - 1; k++) step();
    check("t5_not_yet", bus.UnitErr, 0);
    step();
    check("t5_err", bus.UnitErr, 1);
    check("t5_pend", bus.FlagPending, 0);
    check("t5_flags", bus.Flags, pre);
    // reset while pending, late done ignored
    bus.Valid = 1; bus.FlagW = 4'hF; bus.UnitReq = 2'b10;
    step();
    idle();
    do_reset();
    bus.UnitDone = 2'b10; bus.UnitFlags = 8'hF0;
    step();
    check("t6_flags", bus.Flags, 0);
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      int r;
      bus.Valid = $urandom_range(0, 3) != 0;
      bus.Cond = 4'($urandom);
      bus.FlagW = $urandom_range(0, 1) ? 4'($urandom) : 4'd0;
      bus.PCS = 1'($urandom); bus.RegW = 1'($urandom); bus.MemW = 1'($urandom);
      bus.NoWrite = 1'($urandom); bus.LogicOp = 1'($urandom); bus.ShifterCarry = 1'($urandom);
      bus.ALUFlags = 4'($urandom);
      r = $urandom_range(0, 2*N-1);
      bus.UnitReq = r < N ? N'(1) << r : '0;
      bus.UnitDone = '0;
      for (int i = 0; i < N; i++) bus.UnitDone[i] = m_busy[i] && $urandom_range(0, 2) == 0;
      bus.UnitFlags = (4*N)'($urandom);
      if ($urandom_range(0, 399) == 0) do_reset();
      else step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
